// File: rtl/jump_group_sequencer.sv
// jump_group_sequencer
// Phase-sequenced jump-group (group 2) controller. It captures a jump on DECODE
// and evaluates its condition and target on EXECUTE. On COMMIT it issues a
// one-cycle PC load. It also owns the HALT/wake state and a saturating counter
// of taken jumps.
// Optional feature macro: JUMPGRP_LINK_EN. When defined, taken absolute jumps
// pulse LINK_WEN with PC_LOAD. When undefined, LINK_WEN is tied low.
module jump_group_sequencer #(
  parameter int          PC_W    = 16,
  parameter int          CNT_W   = 8,
  parameter logic [15:0] HALT_OP = 16'h0000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [15:0]      INSTRUCTION,
  input  logic             FETCH,
  input  logic             DECODE,
  input  logic             EXECUTE,
  input  logic             COMMIT,
  input  logic [PC_W-1:0]  PC,
  input  logic [3:0]       FLAGS,
  input  logic [PC_W-1:0]  REGB_DATA,
  input  logic             WAKE,
  output logic [2:0]       REGB_ADDR,
  output logic             PC_EN,
  output logic             PC_LOAD,
  output logic [PC_W-1:0]  PC_NEXT,
  output logic             LINK_WEN,
  output logic [CNT_W-1:0] TAKEN_CNT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODED = 2'd1,
    ST_EVAL    = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  state_t            state_r;
  logic [13:0]       instr_r;
  logic [2:0]        regb_addr_r;
  logic [PC_W-1:0]   pc_next_r;
  logic              taken_r;
  logic              pc_load_r;
  logic              pc_en_r;
  logic              busy_r;
  logic [CNT_W-1:0]  taken_cnt_r;

  logic              is_jump_s;
  logic              halt_s;
  logic [2:0]        regb_sel_s;
  logic [PC_W-1:0]   target_s;
  logic              cond_s;
  logic [15:0]       u16_s;
  logic              unused_s;

  // FETCH carries no information for the jump group.
  assign unused_s  = FETCH;

  assign is_jump_s = (INSTRUCTION[15:14] == 2'b10);
  // A HALT commit is suppressed when WAKE arrives in the same cycle.
  assign halt_s    = COMMIT && (INSTRUCTION == HALT_OP) && !WAKE;
  assign u16_s     = {instr_r[7:0], REGB_DATA[7:0]};

  // Register-file B read select chosen from the instruction being decoded.
  always_comb begin
    regb_sel_s = 3'd0;
    case (INSTRUCTION[11:10])
      2'b00:   regb_sel_s = INSTRUCTION[2:0];
      2'b01:   regb_sel_s = 3'd1;
      2'b11:   regb_sel_s = 3'd1;
      default: regb_sel_s = 3'd0;
    endcase
  end

  // Jump target and condition from the captured instruction; sums wrap at PC_W.
  always_comb begin
    target_s = {PC_W{1'b0}};
    case (instr_r[11:10])
      2'b00:   target_s = REGB_DATA;
      2'b01:   target_s = PC_W'(u16_s);
      2'b10:   target_s = PC + PC_W'($signed(instr_r[7:0]));
      2'b11:   target_s = PC + PC_W'(u16_s);
      default: target_s = REGB_DATA;
    endcase
    cond_s = !instr_r[13] || (FLAGS[instr_r[9:8]] ^ instr_r[12]);
  end

`ifdef JUMPGRP_LINK_EN
  logic link_wen_r;
  assign LINK_WEN = link_wen_r;
`else
  assign LINK_WEN = 1'b0;
`endif

  // Phase sequencer: state, captured fields and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      instr_r     <= 14'd0;
      regb_addr_r <= 3'd0;
      pc_next_r   <= {PC_W{1'b0}};
      taken_r     <= 1'b0;
      pc_load_r   <= 1'b0;
      pc_en_r     <= 1'b1;
      busy_r      <= 1'b0;
      taken_cnt_r <= {CNT_W{1'b0}};
`ifdef JUMPGRP_LINK_EN
      link_wen_r  <= 1'b0;
`endif
    end else begin
      pc_load_r <= 1'b0;
`ifdef JUMPGRP_LINK_EN
      link_wen_r <= 1'b0;
`endif
      if (state_r == ST_HALTED) begin
        if (WAKE) begin
          state_r <= ST_IDLE;
          pc_en_r <= 1'b1;
        end
      end else if (halt_s) begin
        state_r <= ST_HALTED;
        pc_en_r <= 1'b0;
        busy_r  <= 1'b0;
      end else if (DECODE) begin
        if (is_jump_s) begin
          state_r     <= ST_DECODED;
          instr_r     <= INSTRUCTION[13:0];
          regb_addr_r <= regb_sel_s;
          busy_r      <= 1'b1;
        end else begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      end else if ((state_r == ST_DECODED) && EXECUTE) begin
        state_r   <= ST_EVAL;
        pc_next_r <= target_s;
        taken_r   <= cond_s;
      end else if ((state_r == ST_EVAL) && COMMIT) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        if (taken_r) begin
          pc_load_r <= 1'b1;
`ifdef JUMPGRP_LINK_EN
          link_wen_r <= !instr_r[11];
`endif
          if (taken_cnt_r != {CNT_W{1'b1}}) begin
            taken_cnt_r <= taken_cnt_r + CNT_W'(1'b1);
          end
        end
      end
    end
  end

  assign REGB_ADDR = regb_addr_r;
  assign PC_EN     = pc_en_r;
  assign PC_LOAD   = pc_load_r;
  assign PC_NEXT   = pc_next_r;
  assign TAKEN_CNT = taken_cnt_r;
  assign BUSY      = busy_r;

endmodule

// File: tb/tb_jump_group_sequencer.sv
// Self-checking bench for jump_group_sequencer (PC_W=16, CNT_W=8, HALT_OP=0).
module tb_jump_group_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] INSTRUCTION;
  logic        FETCH, DECODE, EXECUTE, COMMIT, WAKE;
  logic [15:0] PC, REGB_DATA;
  logic [3:0]  FLAGS;
  logic [2:0]  REGB_ADDR;
  logic        PC_EN, PC_LOAD, LINK_WEN, BUSY;
  logic [15:0] PC_NEXT;
  logic [7:0]  TAKEN_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  jump_group_sequencer #(.PC_W(16), .CNT_W(8), .HALT_OP(16'h0000)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .FETCH(FETCH),
    .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT), .PC(PC),
    .FLAGS(FLAGS), .REGB_DATA(REGB_DATA), .WAKE(WAKE),
    .REGB_ADDR(REGB_ADDR), .PC_EN(PC_EN), .PC_LOAD(PC_LOAD),
    .PC_NEXT(PC_NEXT), .LINK_WEN(LINK_WEN), .TAKEN_CNT(TAKEN_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] regb;
    logic [3:0]  flags;
    logic [15:0] tgt;
    bit          taken;
    bit          chk_addr;
    logic [2:0]  addr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: target from the field rules using plain integer arithmetic.
  function automatic logic [15:0] ref_target(input logic [15:0] instr, input logic [15:0] pc,
                                             input logic [15:0] regb);
    int t;
    int imm;
    int lo;
    imm = int'(instr[7:0]);
    lo  = int'(regb[7:0]);
    case (instr[11:10])
      2'b00:   t = int'(regb);
      2'b01:   t = imm * 256 + lo;
      2'b10:   t = int'(pc) + ((imm >= 128) ? imm - 256 : imm);
      default: t = int'(pc) + imm * 256 + lo;
    endcase
    return t[15:0];
  endfunction

  function automatic bit ref_taken(input logic [15:0] instr, input logic [3:0] flags);
    return (instr[13] == 1'b0) || (flags[instr[9:8]] != instr[12]);
  endfunction

  function automatic bit exp_link(input logic [15:0] instr, input bit taken);
`ifdef JUMPGRP_LINK_EN
    return taken && (instr[11] == 1'b0);
`else
    return 1'b0 & taken & instr[11];
`endif
  endfunction

  // Full DECODE / EXECUTE / COMMIT sequence with checks after each phase.
  task automatic do_jump(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] regb,
                         input logic [3:0] flags, input logic [15:0] tgt, input bit taken,
                         input bit chk_addr, input logic [2:0] addr);
    INSTRUCTION = instr; DECODE = 1'b1;
    step();
    DECODE = 1'b0;
    if (chk_addr) check("regb_addr", 32'(REGB_ADDR), 32'(addr));
    check("busy_decoded", 32'(BUSY), 32'd1);
    PC = pc; REGB_DATA = regb; FLAGS = flags; EXECUTE = 1'b1;
    step();
    EXECUTE = 1'b0;
    check("pc_next", 32'(PC_NEXT), 32'(tgt));
    check("no_load_eval", 32'(PC_LOAD), 32'd0);
    COMMIT = 1'b1;
    step();
    COMMIT = 1'b0;
    if (taken && exp_cnt < 255) exp_cnt++;
    check("pc_load", 32'(PC_LOAD), 32'(taken));
    check("link_wen", 32'(LINK_WEN), 32'(exp_link(instr, taken)));
    check("taken_cnt", 32'(TAKEN_CNT), 32'(exp_cnt));
    check("busy_after", 32'(BUSY), 32'd0);
    step();
    check("load_single", 32'(PC_LOAD), 32'd0);
  endtask

  task automatic rand_jump(input bit force_taken);
    logic [15:0] instr, pc, regb;
    logic [3:0]  flags;
    instr = {2'b10, 14'($urandom)};
    if (force_taken) instr[13] = 1'b0;
    pc    = 16'($urandom);
    regb  = 16'($urandom);
    flags = 4'($urandom);
    do_jump(instr, pc, regb, flags, ref_target(instr, pc, regb), ref_taken(instr, flags),
            instr[11:10] != 2'b10, (instr[11:10] == 2'b00) ? instr[2:0] : 3'd1);
  endtask

  initial begin
    vecs[0] = '{16'h8003, 16'h0000, 16'h1234, 4'b0000, 16'h1234, 1'b1, 1'b1, 3'd3};
    vecs[1] = '{16'h98FE, 16'h0001, 16'h0000, 4'b0000, 16'hFFFF, 1'b1, 1'b0, 3'd0};
    vecs[2] = '{16'hB805, 16'h0100, 16'h0000, 4'b0001, 16'h0105, 1'b0, 1'b0, 3'd0};
    vecs[3] = '{16'hB805, 16'h0100, 16'h0000, 4'b0000, 16'h0105, 1'b1, 1'b0, 3'd0};
    vecs[4] = '{16'hB103, 16'h0000, 16'h5678, 4'b0010, 16'h5678, 1'b0, 1'b1, 3'd3};
    vecs[5] = '{16'hB103, 16'h0000, 16'h5678, 4'b0000, 16'h5678, 1'b1, 1'b1, 3'd3};
    vecs[6] = '{16'h84AB, 16'h0000, 16'h77CD, 4'b0000, 16'hABCD, 1'b1, 1'b1, 3'd1};
    vecs[7] = '{16'h8C12, 16'hF000, 16'h0034, 4'b0000, 16'h0234, 1'b1, 1'b1, 3'd1};
    vecs[8] = '{16'hA300, 16'h0000, 16'h4321, 4'b1000, 16'h4321, 1'b1, 1'b1, 3'd0};
    vecs[9] = '{16'hA300, 16'h0000, 16'h4321, 4'b0111, 16'h4321, 1'b0, 1'b1, 3'd0};

    RESET = 1'b1; INSTRUCTION = 16'h4000; FETCH = 1'b0; DECODE = 1'b0; EXECUTE = 1'b0;
    COMMIT = 1'b0; WAKE = 1'b0; PC = 16'h0000; REGB_DATA = 16'h0000; FLAGS = 4'b0000;
    step(); step();
    RESET = 1'b0;
    check("rst_pc_en", 32'(PC_EN), 32'd1);
    check("rst_pc_load", 32'(PC_LOAD), 32'd0);
    check("rst_pc_next", 32'(PC_NEXT), 32'd0);
    check("rst_link", 32'(LINK_WEN), 32'd0);
    check("rst_cnt", 32'(TAKEN_CNT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_regb_addr", 32'(REGB_ADDR), 32'd0);

    // Non-jump instruction through all phases: nothing happens.
    for (int i = 0; i < 4; i++) begin
      FETCH = (i == 0); DECODE = (i == 1); EXECUTE = (i == 2); COMMIT = (i == 3);
      step();
      check("idle_pc_load", 32'(PC_LOAD), 32'd0);
      check("idle_busy", 32'(BUSY), 32'd0);
      check("idle_pc_en", 32'(PC_EN), 32'd1);
    end
    FETCH = 1'b0; COMMIT = 1'b0;
    step();
    check("idle_cnt", 32'(TAKEN_CNT), 32'd0);

    for (int i = 0; i < 10; i++)
      do_jump(vecs[i].instr, vecs[i].pc, vecs[i].regb, vecs[i].flags, vecs[i].tgt,
              vecs[i].taken, vecs[i].chk_addr, vecs[i].addr);

    // Out-of-sequence COMMIT ignored, DECODE restart, repeated EXECUTE ignored.
    INSTRUCTION = 16'h8003; DECODE = 1'b1; step(); DECODE = 1'b0;
    COMMIT = 1'b1; step(); COMMIT = 1'b0;
    check("oos_no_load", 32'(PC_LOAD), 32'd0);
    check("oos_busy", 32'(BUSY), 32'd1);
    INSTRUCTION = 16'h8405; DECODE = 1'b1; step(); DECODE = 1'b0;
    check("restart_addr", 32'(REGB_ADDR), 32'd1);
    PC = 16'h0000; REGB_DATA = 16'h2299; EXECUTE = 1'b1; step();
    REGB_DATA = 16'h3311; step(); EXECUTE = 1'b0;
    check("restart_target", 32'(PC_NEXT), 32'h0599);
    COMMIT = 1'b1; step(); COMMIT = 1'b0;
    exp_cnt++;
    check("restart_load", 32'(PC_LOAD), 32'd1);
    check("restart_link", 32'(LINK_WEN), 32'(exp_link(16'h8405, 1'b1)));
    check("restart_cnt", 32'(TAKEN_CNT), 32'(exp_cnt));
    step();

    // HALT, held for 10 cycles, then WAKE.
    INSTRUCTION = 16'h0000; COMMIT = 1'b1; step(); COMMIT = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("halt_pc_en", 32'(PC_EN), 32'd0);
      step();
    end
    WAKE = 1'b1; step(); WAKE = 1'b0;
    check("wake_pc_en", 32'(PC_EN), 32'd1);
    // WAKE coincident with HALT COMMIT: PC_EN never drops.
    COMMIT = 1'b1; WAKE = 1'b1; step(); COMMIT = 1'b0; WAKE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wake_coincident_pc_en", 32'(PC_EN), 32'd1);
      step();
    end

    // Random jumps with random conditions against the reference model.
    for (int i = 0; i < 40; i++) rand_jump(1'b0);
    // Unconditional random jumps driving the counter into saturation.
    for (int i = 0; i < 300; i++) rand_jump(1'b1);
    check("cnt_saturated", 32'(TAKEN_CNT), 32'hFF);

    // RESET between EXECUTE and COMMIT drops the pending load.
    INSTRUCTION = 16'h8003; DECODE = 1'b1; step(); DECODE = 1'b0;
    REGB_DATA = 16'h1234; EXECUTE = 1'b1; step(); EXECUTE = 1'b0;
    RESET = 1'b1; COMMIT = 1'b1; step(); RESET = 1'b0; COMMIT = 1'b0;
    exp_cnt = 0;
    check("midrst_load", 32'(PC_LOAD), 32'd0);
    check("midrst_link", 32'(LINK_WEN), 32'd0);
    check("midrst_cnt", 32'(TAKEN_CNT), 32'(exp_cnt));
    check("midrst_busy", 32'(BUSY), 32'd0);
    COMMIT = 1'b1; step(); COMMIT = 1'b0;
    check("midrst_commit_ignored", 32'(PC_LOAD), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
